mux_scan_sequencer: RTL and testbench

Upstream control stage for the 8:1 enable/select multiplexer. It walks a latched channel mask and drives the mux `select[2:0]` and `enable` lines. Each enabled channel is held for a programmable dwell time. A sample strobe tells the downstream consumer when mux output `y` is settled and should be captured. It supports single-pass and continuous (wrap-around) scanning, with a one-cycle break-before-make gap between channels.

---
 rtl/mux_scan_pkg.sv | 12 +
 rtl/next_channel_finder.sv | 29 ++
 rtl/mux_scan_sequencer.sv | 139 +++++++++++++
 tb/tb_mux_scan_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared constants and state encoding for the mux scan sequencer.
package mux_scan_pkg;
    localparam int SEL_W         = 3;
    localparam int NUM_CH        = 2 ** SEL_W;
    localparam int DWELL_W_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEEK  = 2'd1,
        ST_DWELL = 2'd2
    } scan_state_e;
endpackage

// File: rtl/next_channel_finder.sv
// Combinational priority search: lowest set mask bit at or above from_idx.
module next_channel_finder
    import mux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  from_idx,
    output logic              found,
    output logic [SEL_W-1:0]  idx
);
    logic [NUM_CH-1:0] cand;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
            assign cand[gi] = mask[gi] && (SEL_W'(gi) >= from_idx);
        end
    endgenerate

    // Walk downward so the lowest candidate is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                found = 1'b1;
                idx   = SEL_W'(i);
            end
        end
    end
endmodule

// File: rtl/mux_scan_sequencer.sv
// Walks a latched channel mask, driving mux select/enable with a programmable dwell
// and a one-cycle break-before-make gap between channels.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [NUM_CH-1:0]  ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               continuous,
    output logic [SEL_W-1:0]   select,
    output logic               enable,
    output logic               sample_stb,
    output logic               busy,
    output logic               done
);
    scan_state_e        state_q;
    logic [NUM_CH-1:0]  mask_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] cnt_q;
    logic               cont_q;
    logic [SEL_W-1:0]   search_idx_q;
    logic [SEL_W-1:0]   select_q;
    logic               enable_q;
    logic               stb_q;
    logic               busy_q;
    logic               done_q;

    logic               seek_found;
    logic [SEL_W-1:0]   seek_idx;
    logic               above_found;
    logic [SEL_W-1:0]   above_idx;
    logic [SEL_W-1:0]   above_from_d;
    logic               more_above_d;

    next_channel_finder u_seek (
        .mask     (mask_q),
        .from_idx (search_idx_q),
        .found    (seek_found),
        .idx      (seek_idx)
    );

    // The +1 index wraps at the top channel, so the top channel never has anything above.
    assign above_from_d = select_q + SEL_W'(1);
    assign more_above_d = above_found && (select_q != SEL_W'(NUM_CH - 1));

    next_channel_finder u_above (
        .mask     (mask_q),
        .from_idx (above_from_d),
        .found    (above_found),
        .idx      (above_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            mask_q       <= '0;
            dwell_q      <= '0;
            cnt_q        <= '0;
            cont_q       <= 1'b0;
            search_idx_q <= '0;
            select_q     <= '0;
            enable_q     <= 1'b0;
            stb_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop && (ch_mask != '0)) begin
                        mask_q       <= ch_mask;
                        dwell_q      <= dwell;
                        cont_q       <= continuous;
                        search_idx_q <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= ST_SEEK;
                    end
                end
                ST_SEEK: begin
                    if (stop || !seek_found) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        select_q <= seek_idx;
                        enable_q <= 1'b1;
                        cnt_q    <= dwell_q;
                        stb_q    <= (dwell_q == '0);
                        state_q  <= ST_DWELL;
                    end
                end
                ST_DWELL: begin
                    if (stop) begin
                        enable_q <= 1'b0;
                        stb_q    <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - DWELL_W'(1);
                        stb_q <= (cnt_q == DWELL_W'(1));
                    end else begin
                        enable_q <= 1'b0;
                        stb_q    <= 1'b0;
                        if (more_above_d) begin
                            search_idx_q <= above_from_d;
                            state_q      <= ST_SEEK;
                        end else if (cont_q) begin
                            search_idx_q <= '0;
                            state_q      <= ST_SEEK;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    enable_q <= 1'b0;
                    stb_q    <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign select     = select_q;
    assign enable     = enable_q;
    assign sample_stb = stb_q;
    assign busy       = busy_q;
    assign done       = done_q;

    logic unused_above;
    assign unused_above = ^above_idx;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed test of mux_scan_sequencer: single pass, long dwell, continuous wrap,
// empty mask / stop priority, mid-scan start and async reset mid-dwell.
module tb_mux_scan_sequencer;
    import mux_scan_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               stop;
    logic [NUM_CH-1:0]  ch_mask;
    logic [7:0]         dwell;
    logic               continuous;
    logic [SEL_W-1:0]   select;
    logic               enable;
    logic               sample_stb;
    logic               busy;
    logic               done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_scan_sequencer #(.DWELL_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .ch_mask    (ch_mask),
        .dwell      (dwell),
        .continuous (continuous),
        .select     (select),
        .enable     (enable),
        .sample_stb (sample_stb),
        .busy       (busy),
        .done       (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed as {en, stb, busy, done}
    function automatic logic [3:0] flags();
        return {enable, sample_stb, busy, done};
    endfunction

    initial begin
        int stb_cnt;
        int done_cnt;
        int done_cyc;
        bit ph_en;
        bit ph_stb;
        logic [SEL_W-1:0] exp_ch;

        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        ch_mask = '0; dwell = '0; continuous = 1'b0;
        #3;
        chk("reset_flags", {28'd0, flags()}, 32'h0);
        chk("reset_sel", {29'd0, select}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: mask 0000_0101, dwell 0, single pass
        ch_mask = 8'b0000_0101; dwell = 8'd0; continuous = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        chk("t1_c1_seek", {28'd0, flags()}, 32'b0010);
        tick();
        chk("t1_c2_flags", {28'd0, flags()}, 32'b1110);
        chk("t1_c2_sel", {29'd0, select}, 32'd0);
        tick();
        chk("t1_c3_gap", {28'd0, flags()}, 32'b0010);
        tick();
        chk("t1_c4_flags", {28'd0, flags()}, 32'b1110);
        chk("t1_c4_sel", {29'd0, select}, 32'd2);
        tick();
        chk("t1_c5_done", {28'd0, flags()}, 32'b0001);
        chk("t1_c5_sel_hold", {29'd0, select}, 32'd2);
        tick();
        chk("t1_c6_idle", {28'd0, flags()}, 32'b0000);

        // 2: mask 80, dwell 3
        ch_mask = 8'h80; dwell = 8'd3; start = 1'b1;
        tick(); start = 1'b0;
        chk("t2_c1_seek", {28'd0, flags()}, 32'b0010);
        for (int c = 2; c <= 5; c++) begin
            tick();
            chk($sformatf("t2_c%0d_flags", c), {28'd0, flags()}, (c == 5) ? 32'b1110 : 32'b1010);
            chk($sformatf("t2_c%0d_sel", c), {29'd0, select}, 32'd7);
        end
        tick();
        chk("t2_c6_done", {28'd0, flags()}, 32'b0001);

        // 3: mask 81, dwell 1, continuous; period 3 cycles (gap, dwell, dwell+stb)
        ch_mask = 8'h81; dwell = 8'd1; continuous = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) tick();
            ph_en  = ((c - 1) % 3) != 0;
            ph_stb = ((c - 1) % 3) == 2;
            exp_ch = (((c - 1) / 3) % 2 == 1) ? 3'd7 : 3'd0;
            chk($sformatf("t3_c%0d_flags", c), {28'd0, flags()}, {28'd0, ph_en, ph_stb, 2'b10});
            if (ph_en) chk($sformatf("t3_c%0d_sel", c), {29'd0, select}, {29'd0, exp_ch});
        end
        stop = 1'b1;
        tick(); stop = 1'b0;
        chk("t3_stop_idle", {28'd0, flags()}, 32'b0000);
        tick();
        chk("t3_stop_nodone", {28'd0, flags()}, 32'b0000);

        // 4: empty mask ignored, stop beats start
        ch_mask = 8'h00; continuous = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        chk("t4_empty_c1", {28'd0, flags()}, 32'b0000);
        tick();
        chk("t4_empty_c2", {28'd0, flags()}, 32'b0000);
        ch_mask = 8'hFF; start = 1'b1; stop = 1'b1;
        tick(); start = 1'b0; stop = 1'b0;
        chk("t4_stopwins_c1", {28'd0, flags()}, 32'b0000);
        tick();
        chk("t4_stopwins_c2", {28'd0, flags()}, 32'b0000);

        // 5: mask FF dwell 2; mid-scan reprogram + start must be ignored
        ch_mask = 8'hFF; dwell = 8'd2; continuous = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        stb_cnt = 0; done_cnt = 0; done_cyc = -1;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) tick();
            if (c == 5) begin
                ch_mask = 8'h01; dwell = 8'd0; continuous = 1'b1; start = 1'b1;
            end
            if (c == 6) start = 1'b0;
            if (sample_stb) begin
                chk($sformatf("t5_stb%0d_sel", stb_cnt), {29'd0, select}, stb_cnt);
                chk($sformatf("t5_stb%0d_cycle", stb_cnt), c, 4 * stb_cnt + 4);
                stb_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
        end
        chk("t5_stb_count", stb_cnt, 32'd8);
        chk("t5_done_count", done_cnt, 32'd1);
        chk("t5_done_cycle", done_cyc, 32'd33);

        // 6: async reset during DWELL of ch3, dwell 5
        ch_mask = 8'h08; dwell = 8'd5; continuous = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        chk("t6_pre_rst_flags", {28'd0, flags()}, 32'b1010);
        chk("t6_pre_rst_sel", {29'd0, select}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_flags", {28'd0, flags()}, 32'b0000);
        chk("t6_rst_sel", {29'd0, select}, 32'd0);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk($sformatf("t6_post_%0d", c), {28'd0, flags()}, 32'b0000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
